// File: rtl/jugada_pkg.sv
// Types and constants shared between the move synchronizer and the game controller.
package jugada_pkg;

  typedef logic [2:0] jugada_t;

  localparam int COLUMNAS = 7;
  localparam int MAX_COL  = COLUMNAS - 1;
  localparam int CNT_W    = 8;

  // Increment that holds at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_jugadas.sv
// Show-ahead FIFO of moves; the head is visible on dout whenever the FIFO is non-empty.
module fifo_jugadas
  import jugada_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  jugada_t       din,
  input  logic          pop,
  output jugada_t       dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  jugada_t       mem_q [DEPTH];
  jugada_t       mem_d [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/sincronizador_jugada.sv
// Brings SPI-domain moves into the clk domain, range-checks them and queues legal ones
// for the game FSM, keeping sticky overflow and a saturating error count.
module sincronizador_jugada #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_COL     = jugada_pkg::MAX_COL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  jugada_pkg::jugada_t              jugada_in,
  input  logic                             dato_listo_in,
  output jugada_pkg::jugada_t              jugada_out,
  output logic                             jugada_valid,
  input  logic                             jugada_ready,
  output logic                             error_rango,
  output logic                             overflow,
  output logic [7:0]                       contador_errores,
  input  logic                             clr_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  nivel
);

  import jugada_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   err_rango_q, err_rango_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             cnt_q, cnt_d;

  logic evento, legal, rango, pop, push, drop;
  logic fifo_full, fifo_empty;

  // jugada_in is sampled unsynchronized: it settled with the same sck edge that raised
  // dato_listo_in, which is at least SYNC_STAGES clk edges before the event is seen.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], dato_listo_in};
    prev_d = sync_q[SYNC_STAGES-1];
    evento = sync_q[SYNC_STAGES-1] & ~prev_q;
    legal  = int'(jugada_in) <= MAX_COL;
    rango  = evento & ~legal;
    pop    = ~fifo_empty & jugada_ready;
    push   = evento & legal & (~fifo_full | pop);
    drop   = evento & legal & fifo_full & ~pop;

    err_rango_d = rango;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    cnt_d       = clr_err ? '0 : cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
    end
    // An error in the same cycle as clr_err still counts, leaving the counter at 1.
    if (rango | drop) begin
      cnt_d = sat_inc(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      err_rango_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      err_rango_q <= err_rango_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  fifo_jugadas #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (jugada_in),
    .pop   (pop),
    .dout  (jugada_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (nivel)
  );

  assign jugada_valid     = ~fifo_empty;
  assign error_rango      = err_rango_q;
  assign overflow         = overflow_q;
  assign contador_errores = cnt_q;

endmodule

// File: tb/tb_sincronizador_jugada.sv
// Self-checking bench for sincronizador_jugada against a queue-based move model.
module tb_sincronizador_jugada;

  localparam int S       = 2;
  localparam int DEPTH   = 4;
  localparam int MAXC    = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] jugada_in;
  logic       dato_listo_in;
  logic [2:0] jugada_out;
  logic       jugada_valid;
  logic       jugada_ready;
  logic       error_rango;
  logic       overflow;
  logic [7:0] contador_errores;
  logic       clr_err;
  logic [2:0] nivel;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of accepted moves, error state, and a countdown to the push edge.
  int m_q[$];
  int m_cnt;
  bit m_ovf;
  bit m_err;
  int ev_cnt;
  int ev_move;

  sincronizador_jugada #(
    .SYNC_STAGES (S),
    .FIFO_DEPTH  (DEPTH),
    .MAX_COL     (MAXC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jugada_in        (jugada_in),
    .dato_listo_in    (dato_listo_in),
    .jugada_out       (jugada_out),
    .jugada_valid     (jugada_valid),
    .jugada_ready     (jugada_ready),
    .error_rango      (error_rango),
    .overflow         (overflow),
    .contador_errores (contador_errores),
    .clr_err          (clr_err),
    .nivel            (nivel)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_q.delete();
    m_cnt  = 0;
    m_ovf  = 0;
    m_err  = 0;
    ev_cnt = 0;
  endtask

  function automatic int m_out();
    return (m_q.size() > 0) ? m_q[0] : 0;
  endfunction

  // Advance one clk edge, update the model with the inputs seen at that edge, settle.
  task automatic step();
    bit pop, fire, legal, drop, err;
    @(posedge clk);
    pop  = jugada_ready && (m_q.size() > 0);
    fire = 0;
    if (ev_cnt > 0) begin
      ev_cnt--;
      fire = (ev_cnt == 0);
    end
    legal = (ev_move <= MAXC);
    err   = fire && !legal;
    drop  = fire && legal && (m_q.size() == DEPTH) && !pop;
    if (clr_err) begin
      m_cnt = 0;
      m_ovf = 0;
    end
    if (err || drop) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (drop) m_ovf = 1;
    m_err = err;
    if (pop) void'(m_q.pop_front());
    if (fire && legal && !drop) m_q.push_back(ev_move);
    #1;
  endtask

  task automatic raise(input int mv);
    jugada_in     = 3'(mv);
    dato_listo_in = 1'b1;
    ev_cnt        = S + 1;
    ev_move       = mv;
  endtask

  task automatic send(input int mv);
    raise(mv);
    repeat (S + 1) step();
    dato_listo_in = 1'b0;
    repeat (S + 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; jugada_in = '0; dato_listo_in = 0; jugada_ready = 0; clr_err = 0;
    m_reset();
    #1;
    n_vec++;
    if ({jugada_valid, jugada_out, nivel, error_rango, overflow, contador_errores} !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got valid=%b out=%0d nivel=%0d err=%b ovf=%b cnt=%0d expected all 0",
               jugada_valid, jugada_out, nivel, error_rango, overflow, contador_errores);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_latency();
    raise(3);
    step();
    step();
    n_vec++;
    if (jugada_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL latency_early: got valid=%b expected 0 after edge 2", jugada_valid);
    end
    step();
    n_vec++;
    if (jugada_valid !== 1'b1 || jugada_out !== 3'd3) begin
      n_err++; $display("[TB] FAIL latency_push: got valid=%b out=%0d expected valid=1 out=3", jugada_valid, jugada_out);
    end
    dato_listo_in = 0;
    repeat (S + 1) step();
    jugada_ready = 1;
    step();
    jugada_ready = 0;
    n_vec++;
    if (jugada_valid !== 1'b0 || nivel !== 3'd0) begin
      n_err++; $display("[TB] FAIL latency_pop: got valid=%b nivel=%0d expected 0 0", jugada_valid, nivel);
    end
  endtask

  task automatic test_range_error();
    raise(7);
    repeat (S + 1) step();
    n_vec++;
    if (error_rango !== 1'b1 || contador_errores !== 8'd1 || nivel !== 3'd0 || jugada_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL range_err: got err=%b cnt=%0d nivel=%0d valid=%b expected 1 1 0 0",
               error_rango, contador_errores, nivel, jugada_valid);
    end
    dato_listo_in = 0;
    step();
    n_vec++;
    if (error_rango !== 1'b0) begin
      n_err++; $display("[TB] FAIL range_pulse_width: got err=%b expected 0", error_rango);
    end
    repeat (S) step();
  endtask

  task automatic test_overflow();
    clr_err = 1; step(); clr_err = 0;
    n_vec++;
    if (contador_errores !== 8'd0) begin
      n_err++; $display("[TB] FAIL clr_counter: got %0d expected 0", contador_errores);
    end
    for (int i = 0; i < 5; i++) send(i);
    n_vec++;
    if (nivel !== 3'd4 || overflow !== 1'b1 || contador_errores !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL overflow_state: got nivel=%0d ovf=%b cnt=%0d expected 4 1 1", nivel, overflow, contador_errores);
    end
    jugada_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (jugada_valid !== 1'b1 || int'(jugada_out) !== i) begin
        n_err++; $display("[TB] FAIL overflow_drain: got valid=%b out=%0d expected 1 %0d", jugada_valid, jugada_out, i);
      end
      step();
    end
    jugada_ready = 0;
    n_vec++;
    if (jugada_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL overflow_empty: got valid=%b expected 0", jugada_valid);
    end
  endtask

  task automatic test_full_pop();
    int exp_seq[4] = '{1, 2, 3, 5};
    clr_err = 1; step(); clr_err = 0;
    for (int i = 0; i < 4; i++) send(i);
    raise(5);
    step();
    step();
    jugada_ready = 1;
    step();
    jugada_ready = 0;
    n_vec++;
    if (nivel !== 3'd4 || overflow !== 1'b0 || jugada_out !== 3'd1) begin
      n_err++;
      $display("[TB] FAIL full_pop: got nivel=%0d ovf=%b out=%0d expected 4 0 1", nivel, overflow, jugada_out);
    end
    dato_listo_in = 0;
    repeat (S + 1) step();
    jugada_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (int'(jugada_out) !== exp_seq[i]) begin
        n_err++; $display("[TB] FAIL full_pop_order: got %0d expected %0d", jugada_out, exp_seq[i]);
      end
      step();
    end
    jugada_ready = 0;
  endtask

  task automatic test_held_high();
    raise(2);
    repeat (100) step();
    n_vec++;
    if (nivel !== 3'd1 || jugada_out !== 3'd2) begin
      n_err++; $display("[TB] FAIL held_high: got nivel=%0d out=%0d expected 1 2", nivel, jugada_out);
    end
    dato_listo_in = 0;
    repeat (S + 1) step();
    jugada_ready = 1; step(); jugada_ready = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send(7);
    n_vec++;
    if (contador_errores !== 8'd255) begin
      n_err++; $display("[TB] FAIL saturation: got %0d expected 255", contador_errores);
    end
  endtask

  task automatic test_clr_err();
    raise(7);
    step();
    step();
    clr_err = 1;
    step();
    clr_err = 0;
    n_vec++;
    if (contador_errores !== 8'd1 || error_rango !== 1'b1) begin
      n_err++; $display("[TB] FAIL clr_vs_err: got cnt=%0d err=%b expected 1 1", contador_errores, error_rango);
    end
    dato_listo_in = 0;
    repeat (S + 1) step();
    send(6);
    n_vec++;
    if (jugada_out !== 3'd6 || contador_errores !== 8'd1) begin
      n_err++; $display("[TB] FAIL max_col_legal: got out=%0d cnt=%0d expected 6 1", jugada_out, contador_errores);
    end
    jugada_ready = 1; step(); jugada_ready = 0;
  endtask

  task automatic test_reset_mid();
    send(1);
    send(2);
    raise(4);
    step();
    #2 rst = 1'b0;
    #1;
    m_reset();
    n_vec++;
    if ({jugada_valid, jugada_out, nivel, error_rango, overflow, contador_errores} !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL reset_async: got valid=%b out=%0d nivel=%0d err=%b ovf=%b cnt=%0d expected all 0",
               jugada_valid, jugada_out, nivel, error_rango, overflow, contador_errores);
    end
    dato_listo_in = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) step();
    n_vec++;
    if (jugada_valid !== 1'b0 || nivel !== 3'd0) begin
      n_err++; $display("[TB] FAIL reset_no_push: got valid=%b nivel=%0d expected 0 0", jugada_valid, nivel);
    end
    send(1);
    n_vec++;
    if (jugada_valid !== 1'b1 || jugada_out !== 3'd1) begin
      n_err++; $display("[TB] FAIL reset_new_event: got valid=%b out=%0d expected 1 1", jugada_valid, jugada_out);
    end
    jugada_ready = 1; step(); jugada_ready = 0;
  endtask

  task automatic test_random();
    for (int m = 0; m < 60; m++) begin
      raise(int'($urandom_range(0, 7)));
      for (int k = 0; k < 2 * S + 2; k++) begin
        jugada_ready = ($urandom % 3) == 0;
        clr_err      = ($urandom % 20) == 0;
        if (k == S + 1) dato_listo_in = 0;
        step();
        n_vec++;
        if (int'(nivel) !== m_q.size() || jugada_valid !== (m_q.size() > 0) || int'(jugada_out) !== m_out() ||
            error_rango !== m_err || overflow !== m_ovf || int'(contador_errores) !== m_cnt) begin
          n_err++;
          $display("[TB] FAIL random_cycle: got nivel=%0d valid=%b out=%0d err=%b ovf=%b cnt=%0d expected %0d %b %0d %b %b %0d",
                   nivel, jugada_valid, jugada_out, error_rango, overflow, contador_errores,
                   m_q.size(), m_q.size() > 0, m_out(), m_err, m_ovf, m_cnt);
        end
      end
    end
    jugada_ready = 0;
    clr_err = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_range_error();
    test_overflow();
    test_full_pop();
    test_held_high();
    test_saturation();
    test_clr_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sincronizador_jugada.md
# sincronizador_jugada

Receives the move (`jugada`) and byte-complete flag (`dato_listo`) produced by the SPI slave receiver, which runs in the `sck` domain. It brings them into the system `clk` domain and checks the column range. Valid moves are buffered in a small show-ahead FIFO and handed to the game FSM with a valid/ready handshake. It sits directly downstream of the SPI receiver and upstream of the game controller.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `dato_listo_in` (≥2).
- `FIFO_DEPTH`, 4: buffered moves (power of two, ≥2).
- `MAX_COL`, 6: highest legal column index; 0..MAX_COL are valid.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `jugada_in`, in, 3: move from the SPI receiver (`sck` domain).
- `dato_listo_in`, in, 1: byte-complete flag from the SPI receiver (`sck` domain, asynchronous to `clk`).
- `jugada_out`, out, 3: FIFO head (show-ahead).
- `jugada_valid`, out, 1: FIFO non-empty.
- `jugada_ready`, in, 1: consumer accepts the head this cycle.
- `error_rango`, out, 1: one-cycle pulse when a move > MAX_COL is discarded.
- `overflow`, out, 1: sticky; a legal move was dropped because the FIFO was full.
- `contador_errores`, out, 8: saturating count of range errors plus overflow drops.
- `clr_err`, in, 1: synchronous clear of `overflow` and `contador_errores`.
- `nivel`, out, $clog2(FIFO_DEPTH+1): current occupancy.

## Operation
- `dato_listo_in` passes through a SYNC_STAGES flop chain, then a previous-value flop. A rising edge (`sync_last & ~prev`) is a new-move event.
- On an event, `jugada_in` is sampled directly. It is stable because it changes on the same `sck` edge that raises `dato_listo_in`, and at least SYNC_STAGES `clk` edges have elapsed since then.
- If the sampled move is > MAX_COL: no push, `error_rango` pulses, counter increments.
- If the move is legal and the FIFO is not full: push.
- If the move is legal and the FIFO is full, with no pop that cycle: drop, set `overflow`, counter increments.
- If the move is legal, the FIFO is full and `jugada_ready` pops that same cycle: push accepted, `nivel` unchanged.
- Pop occurs when `jugada_valid & jugada_ready`. `jugada_ready` while empty has no effect.
- `dato_listo_in` held high, with no `sck` activity, produces exactly one event.
- `contador_errores` saturates at 255.
- `clr_err` clears `overflow` and the counter. If an error occurs in the same cycle, the error wins: `overflow` is set, or the counter becomes 1.
- FIFO pointers are width log2(FIFO_DEPTH)+1 and wrap naturally. Full and empty are decoded from the MSB and the pointer equality.

## Timing
- Reset (`rst`=0, asynchronous) clears all sync flops, pointers, `nivel`=0, `jugada_valid`=0, `jugada_out`=0, `error_rango`=0, `overflow`=0, `contador_errores`=0.
- Latency, empty FIFO, SYNC_STAGES=2:
  - `dato_listo_in` is first sampled high at clk edge 1.
  - The event is detected after edge 2.
  - The push occurs at edge 3.
  - `jugada_valid` and `jugada_out` are valid after edge 3.
  - General latency is SYNC_STAGES+1 edges.
- Pop takes effect at the edge where `valid & ready` hold. The next entry, or `valid`=0, appears after that edge.
- `error_rango` is high for exactly the cycle following the detection edge, i.e. coincident with when the push would have happened.
- Input constraint: `dato_listo_in` stays low for at least SYNC_STAGES+1 `clk` cycles between moves. The SPI byte time guarantees this.
- Reset deasserted mid-transfer: synchronizer restarts from 0. A `dato_listo_in` already high is seen as a new event.

## Structure
- Package `jugada_pkg`:
  - `typedef logic [2:0] jugada_t`.
  - `localparam COLUMNAS = 7`.
  - `localparam MAX_COL = COLUMNAS-1`.
  - Shared with the game controller.
- Sub-module `fifo_jugadas`: parameterized show-ahead FIFO with push, pop, full, empty and level outputs.
- Top level: synchronizer, edge detect, range check, error logic.

## Test plan
- Reset, then `jugada_in`=3 with a `dato_listo_in` rise → `jugada_valid`=1 and `jugada_out`=3 after 3 clk edges. `jugada_ready`=1 → valid returns to 0, `nivel`=0.
- `jugada_in`=7 event → one-cycle `error_rango`, counter=1, `nivel`=0, `jugada_valid` stays 0.
- Five legal moves 0,1,2,3,4 with `jugada_ready`=0 → `nivel`=4, `overflow`=1, counter=1. Draining yields 0,1,2,3 in order.
- FIFO full, event with move 5 coinciding with a pop → move accepted, `nivel` stays 4, `overflow` stays 0, 5 appears last.
- `dato_listo_in` held high for 100 cycles → exactly one push. `clr_err` asserted in the same cycle as a range error → counter=1.
- Assert `rst` low while `nivel`=2 and an event is in the sync chain → all outputs return to reset values immediately. No push after release until a new `dato_listo_in` rise is seen.
